// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: shares one FIFO write port among N_REQ requesters, one burst per grant.
// Latency: one IDLE arbitration cycle before each burst; beats then pass through combinationally.
// Backpressure: fifo_full_wr drops req_ready/wr_en of the owner and freezes the burst counters.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TMO  = 8
) (
  input  logic                      clk_wr,
  input  logic                      rst_wr_n,
  input  logic                      en,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full_wr,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BC_W  = $clog2(MAX_BURST) + 1;
  localparam int TC_W  = $clog2(IDLE_TMO) + 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [BC_W-1:0]  BEAT_END = BC_W'(MAX_BURST - 1);
  localparam logic [TC_W-1:0]  TMO_END  = TC_W'(IDLE_TMO - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           state;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] last_idx;
  logic [BC_W-1:0]  beat_cnt;
  logic [TC_W-1:0]  tmo_cnt;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             own_valid;
  logic             own_last;
  logic             burst_done;
  logic             tmo_done;

  // Round-robin pick: first valid requester after the previous owner, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_vld && req_valid[(int'(last_idx) + k) % N_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((int'(last_idx) + k) % N_REQ);
      end
    end
  end

  // Owner-side view of the bus and the two release conditions.
  always_comb begin
    own_valid  = req_valid[gnt_idx];
    own_last   = req_last[gnt_idx];
    burst_done = wr_en && (own_last || (beat_cnt == BEAT_END));
    tmo_done   = !own_valid && (tmo_cnt == TMO_END);
  end

  // Output decode: everything is zero outside BURST; full stalls the owner without releasing it.
  always_comb begin
    grant     = '0;
    req_ready = '0;
    busy      = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    if (state == S_BURST) begin
      grant[gnt_idx]     = 1'b1;
      req_ready[gnt_idx] = !fifo_full_wr;
      busy               = 1'b1;
      wr_en              = own_valid && !fifo_full_wr;
      wr_data            = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    end
  end

  // Arbiter FSM: IDLE grants, BURST counts beats / idle cycles until a release condition.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state    <= S_IDLE;
      gnt_idx  <= '0;
      last_idx <= IDX_LAST;
      beat_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && pick_vld) begin
            gnt_idx  <= pick_idx;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (wr_en) begin
            beat_cnt <= beat_cnt + 1'b1;
            tmo_cnt  <= '0;
            if (burst_done) begin
              last_idx <= gnt_idx;
              state    <= S_IDLE;
            end
          end else if (!own_valid) begin
            if (tmo_done) begin
              last_idx <= gnt_idx;
              state    <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a burst-level model.
// Latency: outputs compared every cycle, #1 after the falling edge where inputs change.
// Backpressure: random fifo_full_wr and en; requesters hold their beat until it is accepted.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int MAX = 16;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   valid;
  logic [N*W-1:0] data;
  logic [N-1:0]   last;
  logic [N-1:0]   ready;
  logic           full;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic [N-1:0]   grant;
  logic           busy;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MAX), .IDLE_TMO(TMO)) dut (
    .clk_wr(clk), .rst_wr_n(rst_n), .en(en),
    .req_valid(valid), .req_data(data), .req_last(last), .req_ready(ready),
    .fifo_full_wr(full), .wr_en(wr_en), .wr_data(wr_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Model: who owns the port (-1 = nobody), previous winner, beats delivered, idle cycles seen.
  int m_owner;
  int m_prev;
  int m_beats;
  int m_idle;
  logic [N-1:0] exp_ready;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_prev  = N - 1;
    m_beats = 0;
    m_idle  = 0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_update();
    bit found;
    int o;
    found = 0;
    if (m_owner < 0) begin
      if (en && (valid != '0)) begin
        for (int k = 1; k <= N; k++) begin
          if (!found && valid[(m_prev + k) % N]) begin
            found   = 1;
            m_owner = (m_prev + k) % N;
            m_beats = 0;
            m_idle  = 0;
          end
        end
      end
    end else begin
      o = m_owner;
      if (valid[o] && !full) begin
        m_beats++;
        m_idle = 0;
        if (last[o] || m_beats == MAX) begin
          m_prev  = o;
          m_owner = -1;
        end
      end else if (!valid[o]) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_prev  = o;
          m_owner = -1;
        end
      end
    end
  endtask

  // Compare every output against what the model says this cycle must show.
  task automatic check();
    logic [N-1:0] e_grant;
    logic         e_busy;
    logic         e_wr;
    logic [W-1:0] e_data;
    #1;
    if (!rst_n) model_reset();
    e_grant   = '0;
    exp_ready = '0;
    e_busy    = 1'b0;
    e_wr      = 1'b0;
    e_data    = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_busy           = 1'b1;
      if (!full) exp_ready[m_owner] = 1'b1;
      e_wr   = valid[m_owner] && !full;
      e_data = data[m_owner*W +: W];
    end
    cmp("grant", 32'(grant), 32'(e_grant));
    cmp("busy", 32'(busy), 32'(e_busy));
    cmp("req_ready", 32'(ready), 32'(exp_ready));
    cmp("wr_en", 32'(wr_en), 32'(e_wr));
    cmp("wr_data", 32'(wr_data), 32'(e_data));
  endtask

  task automatic clk_edge();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    valid = '0;
    last  = '0;
    full  = 1'b0;
    check();
    clk_edge();
    rst_n = 1'b1;
  endtask

  task automatic new_beat(input int i, input int pl);
    data[i*W +: W] = W'($urandom_range(0, 255));
    last[i]        = ($urandom_range(0, 99) < pl);
  endtask

  task automatic run_random(input int cycles, input int pv, input int pl, input int pf, input int pen);
    logic [N-1:0] acc;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) valid[i] = ($urandom_range(0, 99) < pv);
      full = ($urandom_range(0, 99) < pf);
      en   = ($urandom_range(0, 99) < pen);
      check();
      acc = valid & exp_ready;
      clk_edge();
      for (int i = 0; i < N; i++) if (acc[i]) new_beat(i, pl);
    end
  endtask

  logic [N-1:0] seq2 [10];
  logic [N-1:0] owners3 [$];
  int           beats3 [$];
  logic [N-1:0] prev_g;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    valid = '0;
    last  = '0;
    data  = '0;
    full  = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state, then a three-beat packet from requester 0.
    check();
    cmp("rst_grant", 32'(grant), 32'h0);
    cmp("rst_wr_en", 32'(wr_en), 32'h0);
    cmp("rst_wr_data", 32'(wr_data), 32'h0);
    clk_edge();
    rst_n = 1'b1;
    valid = 4'b0001;
    data[7:0] = 8'hA1;
    check();
    cmp("t1_c0_grant", 32'(grant), 32'h0);
    clk_edge();
    check();
    cmp("t1_c1_grant", 32'(grant), 32'h1);
    cmp("t1_c1_data", 32'(wr_data), 32'hA1);
    clk_edge();
    data[7:0] = 8'hA2;
    check();
    cmp("t1_c2_data", 32'(wr_data), 32'hA2);
    clk_edge();
    data[7:0] = 8'hA3;
    last[0] = 1'b1;
    check();
    cmp("t1_c3_wr_en", 32'(wr_en), 32'h1);
    cmp("t1_c3_data", 32'(wr_data), 32'hA3);
    clk_edge();
    valid = '0;
    last  = '0;
    check();
    cmp("t1_c4_busy", 32'(busy), 32'h0);
    clk_edge();

    // Everyone valid with last on every beat: one beat per grant, IDLE in between.
    do_reset();
    seq2 = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    valid = 4'b1111;
    last  = 4'b1111;
    data  = 32'h44332211;
    for (int c = 0; c < 10; c++) begin
      check();
      cmp($sformatf("t2_grant_%0d", c), 32'(grant), 32'(seq2[c]));
      clk_edge();
    end

    // Requesters 1 and 2 stream without last: bursts cut at MAX beats, round robin r1, r2, r1.
    do_reset();
    valid = 4'b0110;
    last  = '0;
    prev_g = '0;
    for (int c = 0; c < 60; c++) begin
      check();
      if (grant != '0 && prev_g == '0) begin
        owners3.push_back(grant);
        beats3.push_back(0);
      end
      if (wr_en && beats3.size() > 0) beats3[beats3.size()-1]++;
      prev_g = grant;
      clk_edge();
    end
    if (owners3.size() >= 3) begin
      cmp("t3_owner0", 32'(owners3[0]), 32'h2);
      cmp("t3_owner1", 32'(owners3[1]), 32'h4);
      cmp("t3_owner2", 32'(owners3[2]), 32'h2);
      cmp("t3_beats0", 32'(beats3[0]), 32'd16);
      cmp("t3_beats1", 32'(beats3[1]), 32'd16);
    end else begin
      cmp("t3_grant_count", 32'(owners3.size()), 32'd3);
    end

    // FIFO full for 20 cycles mid-burst: no writes, no ready, no release.
    do_reset();
    valid = 4'b0001;
    last  = '0;
    data[7:0] = 8'h40;
    check();
    clk_edge();
    check();
    cmp("t4_first_beat", 32'(wr_en), 32'h1);
    clk_edge();
    data[7:0] = 8'h41;
    full = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check();
      if (c == 0 || c == 19) begin
        cmp($sformatf("t4_stall_wr_en_%0d", c), 32'(wr_en), 32'h0);
        cmp($sformatf("t4_stall_ready_%0d", c), 32'(ready), 32'h0);
        cmp($sformatf("t4_stall_grant_%0d", c), 32'(grant), 32'h1);
      end
      clk_edge();
    end
    full = 1'b0;
    last[0] = 1'b1;
    check();
    cmp("t4_resume_wr_en", 32'(wr_en), 32'h1);
    cmp("t4_resume_data", 32'(wr_data), 32'h41);
    clk_edge();
    valid = '0;
    last  = '0;

    // Requester 3 goes quiet after two beats: released after IDLE_TMO idle cycles.
    do_reset();
    valid = 4'b1000;
    for (int c = 0; c <= 12; c++) begin
      if (c == 3) valid = 4'b0001;
      check();
      if (c == 1)  cmp("t5_c1_grant", 32'(grant), 32'h8);
      if (c == 10) cmp("t5_c10_grant", 32'(grant), 32'h8);
      if (c == 11) cmp("t5_c11_grant", 32'(grant), 32'h0);
      if (c == 12) cmp("t5_c12_grant", 32'(grant), 32'h1);
      clk_edge();
    end

    // en dropped mid-burst: burst still ends normally, then no grant until en returns.
    do_reset();
    valid = 4'b0010;
    last  = '0;
    for (int c = 0; c <= 8; c++) begin
      if (c == 2) en = 1'b0;
      last[1] = (c == 3);
      if (c == 7) en = 1'b1;
      check();
      if (c == 3) cmp("t6_last_beat", 32'(wr_en), 32'h1);
      if (c >= 4 && c <= 7) cmp($sformatf("t6_blocked_%0d", c), 32'(grant), 32'h0);
      if (c == 8) cmp("t6_regrant", 32'(grant), 32'h2);
      clk_edge();
    end
    // Reset mid-burst takes effect without a clock edge.
    rst_n = 1'b0;
    check();
    cmp("t6_rst_grant", 32'(grant), 32'h0);
    cmp("t6_rst_wr_en", 32'(wr_en), 32'h0);
    clk_edge();
    rst_n = 1'b1;

    // Randomized traffic: dense, sparse (timeouts), long packets (MAX cuts), heavy backpressure.
    for (int i = 0; i < N; i++) new_beat(i, 30);
    run_random(600, 85, 30, 15, 95);
    run_random(500, 35, 30, 10, 90);
    run_random(500, 90, 0, 10, 100);
    run_random(400, 70, 20, 60, 70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
